// File: rtl/armleocpu_ptw.sv
// Sv32 hardware page table walker for ArmleoCPU.
// Walks the two-level Sv32 table over a single-outstanding read port and
// returns a 4K physical tag plus PTE metadata, or a page/access fault.
// Optional feature macro: ARMLEOCPU_PTW_SUPERPAGE_EN (when defined, level-1
// leaves are split into the requested 4K slice; otherwise they fault).
module armleocpu_ptw #(
  parameter int MEM_ADDR_W = 34
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  resolve_request,
  output logic                  resolve_ack,
  input  logic [19:0]           resolve_virtual_address,
  input  logic [21:0]           satp_ppn,
  output logic                  resolve_done,
  output logic                  resolve_pagefault,
  output logic                  resolve_accessfault,
  output logic [21:0]           resolve_physical_address,
  output logic [7:0]            resolve_metadata,
  output logic                  m_valid,
  output logic [MEM_ADDR_W-1:0] m_addr,
  input  logic                  m_ready,
  input  logic                  m_rvalid,
  input  logic [31:0]           m_rdata,
  input  logic                  m_rerr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  state, state_next;
  logic                    level, level_next;
  logic [9:0]              vpn_lo, vpn_lo_next;
  logic [MEM_ADDR_W-1:0]   addr, addr_next;
  logic                    pf, pf_next;
  logic                    af, af_next;
  logic [21:0]             ptag, ptag_next;
  logic [7:0]              meta, meta_next;

  // PTE flag decode of the response word
  logic pte_v, pte_r, pte_w, pte_x, pte_a;
  assign pte_v = m_rdata[0];
  assign pte_r = m_rdata[1];
  assign pte_w = m_rdata[2];
  assign pte_x = m_rdata[3];
  assign pte_a = m_rdata[6];

  // RSW bits carry no meaning for the walker
  logic [1:0] unused_pte_bits;
  assign unused_pte_bits = m_rdata[9:8];

  // PTE address: table base {ppn, 12'b0} plus index*4; low 12 bits never carry
  function automatic logic [MEM_ADDR_W-1:0] pte_addr(input logic [21:0] ppn,
                                                     input logic [9:0]  idx);
    return MEM_ADDR_W'({ppn, idx, 2'b00});
  endfunction

  assign resolve_ack              = (state == S_IDLE) && resolve_request;
  assign resolve_done             = (state == S_DONE);
  assign m_valid                  = (state == S_ISSUE);
  assign m_addr                   = addr;
  assign resolve_pagefault        = pf;
  assign resolve_accessfault      = af;
  assign resolve_physical_address = ptag;
  assign resolve_metadata         = meta;

  // Next-state logic: walk control and PTE evaluation
  always_comb begin
    state_next  = state;
    level_next  = level;
    vpn_lo_next = vpn_lo;
    addr_next   = addr;
    pf_next     = pf;
    af_next     = af;
    ptag_next   = ptag;
    meta_next   = meta;
    case (state)
      S_IDLE: begin
        if (resolve_request) begin
          state_next  = S_ISSUE;
          level_next  = 1'b1;
          vpn_lo_next = resolve_virtual_address[9:0];
          addr_next   = pte_addr(satp_ppn, resolve_virtual_address[19:10]);
          pf_next     = 1'b0;
          af_next     = 1'b0;
          ptag_next   = 22'd0;
          meta_next   = 8'd0;
        end else begin
          state_next = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (m_ready) begin
          state_next = S_WAIT;
        end else begin
          state_next = S_ISSUE;
        end
      end
      S_WAIT: begin
        if (m_rvalid) begin
          state_next = S_DONE;
          if (m_rerr) begin
            af_next = 1'b1;
          end else if (!pte_v || (!pte_r && pte_w)) begin
            pf_next = 1'b1;
          end else if (pte_r || pte_x) begin
            if (!pte_a) begin
              pf_next = 1'b1;
            end else if (level) begin
`ifdef ARMLEOCPU_PTW_SUPERPAGE_EN
              // Superpage must be 4M aligned; hand back the requested 4K slice
              if (m_rdata[19:10] != 10'd0) begin
                pf_next = 1'b1;
              end else begin
                ptag_next = {m_rdata[31:20], vpn_lo};
                meta_next = m_rdata[7:0];
              end
`else
              pf_next = 1'b1;
`endif
            end else begin
              ptag_next = m_rdata[31:10];
              meta_next = m_rdata[7:0];
            end
          end else if (level) begin
            state_next = S_ISSUE;
            level_next = 1'b0;
            addr_next  = pte_addr(m_rdata[31:10], vpn_lo);
          end else begin
            pf_next = 1'b1;
          end
        end else begin
          state_next = S_WAIT;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      level  <= 1'b0;
      vpn_lo <= 10'd0;
      addr   <= '0;
      pf     <= 1'b0;
      af     <= 1'b0;
      ptag   <= 22'd0;
      meta   <= 8'd0;
    end else begin
      state  <= state_next;
      level  <= level_next;
      vpn_lo <= vpn_lo_next;
      addr   <= addr_next;
      pf     <= pf_next;
      af     <= af_next;
      ptag   <= ptag_next;
      meta   <= meta_next;
    end
  end

endmodule

// File: tb/tb_armleocpu_ptw.sv
// Testbench for armleocpu_ptw: directed table walks plus randomized walks
// checked against a behavioural Sv32 walk model over a sparse memory array.
module tb_armleocpu_ptw;

  logic        clk = 1'b0;
  logic        rst;
  logic        resolve_request;
  logic        resolve_ack;
  logic [19:0] resolve_virtual_address;
  logic [21:0] satp_ppn;
  logic        resolve_done;
  logic        resolve_pagefault;
  logic        resolve_accessfault;
  logic [21:0] resolve_physical_address;
  logic [7:0]  resolve_metadata;
  logic        m_valid;
  logic [33:0] m_addr;
  logic        m_ready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_rerr;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [logic [33:0]];

  armleocpu_ptw #(.MEM_ADDR_W(34)) dut (
    .clk(clk), .rst(rst),
    .resolve_request(resolve_request), .resolve_ack(resolve_ack),
    .resolve_virtual_address(resolve_virtual_address), .satp_ppn(satp_ppn),
    .resolve_done(resolve_done), .resolve_pagefault(resolve_pagefault),
    .resolve_accessfault(resolve_accessfault),
    .resolve_physical_address(resolve_physical_address),
    .resolve_metadata(resolve_metadata),
    .m_valid(m_valid), .m_addr(m_addr), .m_ready(m_ready),
    .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_rerr(m_rerr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd(input logic [33:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0;
  endfunction

  // Behavioural Sv32 walk: follows the table with plain arithmetic
  function automatic void ref_walk(input logic [21:0] satp, input logic [19:0] vpn,
                                   input bit err1, input bit err0,
                                   output bit pf, output bit af,
                                   output logic [21:0] ptag, output logic [7:0] meta,
                                   output int nlev, output logic [33:0] a1,
                                   output logic [33:0] a0);
    logic [31:0] pte;
    longint      addr;
    int          lvl;
    pf = 0; af = 0; ptag = 22'd0; meta = 8'd0; nlev = 0; a0 = 34'd0;
    addr = longint'(satp) * 4096 + longint'(vpn / 1024) * 4;
    a1   = addr[33:0];
    lvl  = 1;
    for (int step = 0; step < 2; step++) begin
      pte = rd(addr[33:0]);
      nlev++;
      if ((lvl == 1 && err1) || (lvl == 0 && err0)) begin af = 1; return; end
      if (pte[0] == 1'b0 || (pte[2] == 1'b1 && pte[1] == 1'b0)) begin pf = 1; return; end
      if (pte[1] == 1'b1 || pte[3] == 1'b1) begin
        if (pte[6] == 1'b0) begin pf = 1; return; end
        if (lvl == 1) begin
`ifdef ARMLEOCPU_PTW_SUPERPAGE_EN
          if ((pte / 1024) % 1024 != 0) pf = 1;
          else begin
            ptag = 22'((pte / 1048576) * 1024 + 32'(vpn % 1024));
            meta = 8'(pte % 256);
          end
`else
          pf = 1;
`endif
        end else begin
          ptag = 22'(pte / 1024);
          meta = 8'(pte % 256);
        end
        return;
      end
      if (lvl == 0) begin pf = 1; return; end
      addr = longint'(pte / 1024) * 4096 + longint'(vpn % 1024) * 4;
      a0   = addr[33:0];
      lvl  = 0;
    end
  endfunction

  // Random PTE of a given class
  function automatic logic [31:0] gen_pte(input int kind);
    logic [21:0] ppn;
    logic [7:0]  fl;
    bit          r, w, x;
    ppn = 22'($urandom);
    r = 1'($urandom); x = r ? 1'($urandom) : 1'b1; w = r ? 1'($urandom) : 1'b0;
    fl = {1'($urandom), 1'b1, 1'($urandom), 1'($urandom), x, w, r, 1'b1};
    case (kind)
      0: ;
      1: ppn[9:0] = 10'd0;
      2: fl = {1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 4'b0001};
      3: fl[0] = 1'b0;
      4: begin fl[1] = 1'b0; fl[2] = 1'b1; fl[0] = 1'b1; end
      5: fl[6] = 1'b0;
      default: ;
    endcase
    return {ppn, 2'($urandom), fl};
  endfunction

  // One walk with a responsive memory; checks addresses, result and latency
  task automatic do_walk(input string nm, input logic [21:0] satp, input logic [19:0] vpn,
                         input bit err1, input bit err0, input int stall1, input int dly,
                         output bit g_pf, output bit g_af, output logic [21:0] g_ptag,
                         output logic [7:0] g_meta, output int g_lat);
    bit e_pf, e_af, done, pending;
    logic [21:0] e_ptag;
    logic [7:0]  e_meta;
    logic [33:0] a1, a0, resp_addr;
    int nlev, e_lat, cyc, issue, wait_c, stall_left;
    bit resp_err;
    ref_walk(satp, vpn, err1, err0, e_pf, e_af, e_ptag, e_meta, nlev, a1, a0);
    e_lat = 1 + stall1 + nlev * (2 + dly);
    g_pf = 0; g_af = 0; g_ptag = 22'd0; g_meta = 8'd0; g_lat = -1;
    resolve_request = 1'b1; resolve_virtual_address = vpn; satp_ppn = satp;
    #1 check({nm, "_ack"}, resolve_ack, 1);
    @(posedge clk); @(negedge clk);
    resolve_request = 1'b0;
    resolve_virtual_address = 20'($urandom); satp_ppn = 22'($urandom);
    cyc = 1; issue = 0; pending = 0; wait_c = 0; stall_left = stall1; done = 0;
    resp_addr = 34'd0; resp_err = 0;
    while (!done && cyc < 60) begin
      m_ready = 1'b0; m_rvalid = 1'b0; m_rerr = 1'b0; m_rdata = $urandom;
      if (resolve_done) begin
        done = 1; resolve_request = 1'b0;
        g_pf = resolve_pagefault; g_af = resolve_accessfault;
        g_ptag = resolve_physical_address; g_meta = resolve_metadata; g_lat = cyc;
        check({nm, "_pf"}, g_pf, e_pf);
        check({nm, "_af"}, g_af, e_af);
        check({nm, "_ptag"}, g_ptag, e_ptag);
        check({nm, "_meta"}, g_meta, e_meta);
        check({nm, "_lat"}, cyc, e_lat);
      end else begin
        if (pending) begin
          if (wait_c == 0) begin
            m_rvalid = 1'b1; m_rdata = rd(resp_addr); m_rerr = resp_err; pending = 0;
          end else begin
            wait_c--;
          end
        end else if (m_valid) begin
          check({nm, "_maddr"}, m_addr, (issue == 0) ? a1 : a0);
          if (stall_left > 0) begin
            stall_left--;
            if ($urandom_range(1, 0) == 1) begin m_rvalid = 1'b1; m_rerr = 1'($urandom); end
          end else begin
            m_ready = 1'b1; pending = 1; wait_c = dly;
            resp_addr = (issue == 0) ? a1 : a0;
            resp_err  = (issue == 0) ? err1 : err0;
            issue++;
          end
        end
        resolve_request = 1'($urandom);
        #1 if (resolve_request) check({nm, "_ack_busy"}, resolve_ack, 0);
        @(negedge clk);
        cyc++;
      end
    end
    m_ready = 1'b0; m_rvalid = 1'b0; m_rerr = 1'b0;
    if (!done) check({nm, "_timeout"}, 0, 1);
    @(negedge clk);
    check({nm, "_done_pulse"}, resolve_done, 0);
  endtask

  initial begin
    bit pf, af;
    logic [21:0] ptag;
    logic [7:0]  meta;
    int lat, seen;
    logic [21:0] satp;
    logic [19:0] vpn;
    logic [33:0] a1, a0;
    logic [31:0] pte1;

    rst = 1'b1; resolve_request = 1'b0; resolve_virtual_address = 20'd0; satp_ppn = 22'd0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 32'd0; m_rerr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", resolve_ack, 0);
    check("rst_done", resolve_done, 0);
    check("rst_pf", resolve_pagefault, 0);
    check("rst_af", resolve_accessfault, 0);
    check("rst_ptag", resolve_physical_address, 0);
    check("rst_meta", resolve_metadata, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_maddr", m_addr, 0);
    rst = 1'b0;
    @(negedge clk);

    // 4K two-level walk
    mem.delete(); mem[34'h1004] = 32'h00000801; mem[34'h200C] = 32'h048D14CF;
    do_walk("w4k", 22'h1, 20'h00403, 0, 0, 0, 0, pf, af, ptag, meta, lat);
    check("w4k_ptag_c", ptag, 22'h12345);
    check("w4k_meta_c", meta, 8'hCF);
    check("w4k_lat_c", lat, 5);
    check("w4k_flt_c", {pf, af}, 2'b00);

    // Superpage
    mem.delete(); mem[34'h1004] = 32'h0010004B;
    do_walk("sp", 22'h1, 20'h00403, 0, 0, 0, 0, pf, af, ptag, meta, lat);
`ifdef ARMLEOCPU_PTW_SUPERPAGE_EN
    check("sp_ptag_c", ptag, 22'h00403);
    check("sp_meta_c", meta, 8'h4B);
    check("sp_lat_c", lat, 3);
    check("sp_pf_c", pf, 0);
`else
    check("sp_pf_c", pf, 1);
    check("sp_ptag_c", ptag, 22'h0);
`endif

    // Misaligned superpage
    mem.delete(); mem[34'h1004] = 32'h0010044B;
    do_walk("spmis", 22'h1, 20'h00403, 0, 0, 0, 0, pf, af, ptag, meta, lat);
    check("spmis_c", {pf, af}, 2'b10);

    // Invalid PTE forms
    mem.delete(); mem[34'h1004] = 32'h00000800;
    do_walk("v0", 22'h1, 20'h00403, 0, 0, 0, 0, pf, af, ptag, meta, lat);
    check("v0_pf_c", pf, 1);
    mem.delete(); mem[34'h1004] = 32'h00000C45;
    do_walk("r0w1", 22'h1, 20'h00403, 0, 0, 0, 0, pf, af, ptag, meta, lat);
    check("r0w1_pf_c", pf, 1);
    mem.delete(); mem[34'h1004] = 32'h0010000B;
    do_walk("a0", 22'h1, 20'h00403, 0, 0, 0, 0, pf, af, ptag, meta, lat);
    check("a0_pf_c", pf, 1);
    mem.delete(); mem[34'h1004] = 32'h00000801; mem[34'h200C] = 32'h00000401;
    do_walk("nl0", 22'h1, 20'h00403, 0, 0, 0, 0, pf, af, ptag, meta, lat);
    check("nl0_pf_c", pf, 1);

    // Bus error on level 0 with 3 stall cycles
    mem.delete(); mem[34'h1004] = 32'h00000801; mem[34'h200C] = 32'h048D14CF;
    do_walk("berr", 22'h1, 20'h00403, 0, 1, 3, 0, pf, af, ptag, meta, lat);
    check("berr_flt_c", {pf, af}, 2'b01);
    check("berr_lat_c", lat, 8);

    // Reset mid-walk, then stray response in IDLE
    resolve_request = 1'b1; resolve_virtual_address = 20'h00403; satp_ppn = 22'h1;
    @(posedge clk); @(negedge clk);
    resolve_request = 1'b0; m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_mvalid", m_valid, 0);
    m_rvalid = 1'b1; m_rdata = 32'h048D14CF;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      m_rvalid = 1'b0;
      if (resolve_done || m_valid) seen++;
    end
    check("rstw_quiet", seen, 0);
    do_walk("rstw", 22'h1, 20'h00403, 0, 0, 0, 0, pf, af, ptag, meta, lat);
    check("rstw_ptag_c", ptag, 22'h12345);
    check("rstw_lat_c", lat, 5);

    // Randomized walks
    for (int it = 0; it < 150; it++) begin
      satp = 22'($urandom); vpn = 20'($urandom);
      mem.delete();
      pte1 = gen_pte(($urandom_range(1, 0) == 1) ? 2 : int'($urandom_range(5, 0)));
      a1 = 34'(longint'(satp) * 4096 + longint'(vpn / 1024) * 4);
      mem[a1] = pte1;
      a0 = 34'(longint'(pte1 / 1024) * 4096 + longint'(vpn % 1024) * 4);
      if (a0 != a1) mem[a0] = gen_pte(int'($urandom_range(5, 0)));
      do_walk("rnd", satp, vpn, $urandom_range(7, 0) == 0, $urandom_range(7, 0) == 0,
              int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
              pf, af, ptag, meta, lat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
